bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Parametrised round-robin bus arbiter for the serial system bus. It replaces the fixed two-master arbitration with N masters and rotating priority. A hold-time watchdog forcibly reclaims the bus from a master that overstays. It sits between the master ports (breq/bgrant/ack handshake) and the bus address decoder/mux, and drives the owner index that steers the data muxes.

## Interface
- NUM_MASTERS, 2, number of requesting master ports (≥2).
- MAX_HOLD, 256, maximum consecutive granted cycles per tenure; 0 disables the watchdog.
- IDX_W, $clog2(NUM_MASTERS), width of owner index (derived localparam, minimum 1).
- clk  input  1  bus clock; sole clock.
- rstn  input  1  reset, synchronous, active-low.
- breq  input  NUM_MASTERS  per-master bus request, held high for the whole transaction.
- bgrant  output  NUM_MASTERS  one-hot (or zero) grant.
- ack  output  NUM_MASTERS  one-cycle pulse to the granted master on the first grant cycle.
- owner  output  IDX_W  index of current/last owner; valid when busy=1.
- busy  output  1  high while any bgrant bit is high.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant.
- lockout  output  NUM_MASTERS  masters currently barred after a timeout (status).

## Operation
- State machine has two states: IDLE and GRANT. Registers: state, bgrant, ack, owner, last (last owner), hold_cnt, lockout.
- IDLE:
  - bgrant=0. Compute eligible = breq & ~lockout.
  - If eligible≠0, pick the first set bit searching upward from (last+1) mod NUM_MASTERS, wrapping.
  - Next cycle: state=GRANT, bgrant=onehot(winner), ack=onehot(winner), owner=winner, hold_cnt=0.
- GRANT:
  - ack=0 after its first cycle. hold_cnt increments every cycle and saturates.
  - If breq[owner]=0: bgrant←0, last←owner, state←IDLE (normal release).
  - Else if MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1: bgrant←0, last←owner, lockout[owner]←1, timeout pulses, state←IDLE.
  - Normal release takes precedence over timeout in the same cycle.
- Lockout bit i clears in any cycle where breq[i]=0, in any state. A locked master must drop breq for ≥1 cycle before it is eligible again.
- Requests from non-owners during GRANT are ignored until IDLE. No preemption except the watchdog.
- Simultaneous requests in IDLE: rotation decides. With all masters requesting continuously, grants cycle 0,1,…,N-1,0.
- breq of a non-eligible (locked) master never produces a grant, even if it is the only request.
- hold_cnt width is $clog2(MAX_HOLD+1), minimum 1.

## Timing
- Reset (rstn=0 at clk edge): state=IDLE, bgrant=0, ack=0, owner=0, busy=0, timeout=0, lockout=0, hold_cnt=0, last=NUM_MASTERS-1, so master 0 wins first.
- Reset mid-tenure drops bgrant on the next edge with no timeout pulse.
- Grant latency: breq sampled high in IDLE at edge k gives bgrant/ack high from edge k+1.
- Release: breq low sampled at edge k gives bgrant low from edge k+1. IDLE lasts exactly one cycle before the next grant, which is the bus turnaround cycle.
- Timeout: bgrant is high for exactly MAX_HOLD cycles. timeout is high during the first cycle with bgrant=0.
- Back-to-back tenures therefore cost 1 dead cycle. Minimum tenure is 1 cycle.
- All outputs are registered; no combinational path from breq to any output.

## Structure
- Shared package bus_pkg: arbiter state encoding (IDLE/GRANT), common DATA_WIDTH/ADDR_WIDTH defaults, and the onehot and wrap-increment helper functions used across bus blocks.
- One sub-module: rr_pick. It is purely combinational; inputs are req vector and last index, outputs are winner index and found flag, implemented by double-width rotate-and-priority-encode. It is reused by the future slave-side response arbiter.

## Test plan
- Reset then m0 breq held 5 cycles, NUM_MASTERS=2 → bgrant=01 one cycle after request, ack pulse 1 cycle, bgrant low one cycle after breq drops, owner=0.
- NUM_MASTERS=4, all breq high permanently, each master drops breq 3 cycles into its tenure → grant order 0,1,2,3,0 with exactly one idle cycle between tenures.
- NUM_MASTERS=3, last owner=1, m0 and m2 request in same cycle → m2 granted, then m0.
- MAX_HOLD=8, m1 holds breq 20 cycles while m0 also requests → m1 bgrant exactly 8 cycles, timeout pulse, m0 granted next. m1 is not regranted until it drops breq for one cycle and re-requests.
- MAX_HOLD=8, m0 drops breq on cycle 8 of its tenure (same cycle as limit) → normal release, no timeout, lockout stays 0.
- rstn asserted mid-tenure of m2 → bgrant=0, busy=0 next edge; after reset, first grant goes to m0 when m0 and m2 both request.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus state encoding, default widths and helper functions
package bus_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] onehot(input int i);
    return 32'd1 << i;
  endfunction
  function automatic int wrap_inc(input int i, input int n);
    return i + 1 >= n ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: master-port handshake bundle between masters and the arbiter
interface bus_arbiter_rr_if #(parameter int NUM_MASTERS = 2);
  import bus_pkg::*;
  localparam int IDX_W = clog2_min1(NUM_MASTERS);
  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [NUM_MASTERS-1:0] ack;
  logic [NUM_MASTERS-1:0] lockout;
  logic [IDX_W-1:0] owner;
  logic busy;
  logic timeout;
  modport master(output breq, input bgrant, ack, owner, busy, timeout, lockout);
  modport slave(input breq, output bgrant, ack, owner, busy, timeout, lockout);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search upward from last+1 via double-width rotate
module rr_pick import bus_pkg::*; #(
  parameter int N = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             found
);
  int start;
  logic [N-1:0] rot;
  always_comb begin
    start = wrap_inc(int'(last), N);
    rot = N'({req, req} >> start);
    found = |req;
    winner = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) winner = IDX_W'((start + i) % N);
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin bus arbiter with hold-time watchdog
module bus_arbiter_rr import bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD = 256
) (
  input logic clk,
  input logic rstn,
  bus_arbiter_rr_if.slave bus
);
  localparam int IDX_W = clog2_min1(NUM_MASTERS);
  localparam int HC_W = clog2_min1(MAX_HOLD + 1);
  arb_state_t state, state_n;
  logic [NUM_MASTERS-1:0] bgrant, bgrant_n, ack, ack_n, lockout, lockout_n, eligible;
  logic [IDX_W-1:0] owner, owner_n, last, last_n, winner;
  logic [HC_W-1:0] hold_cnt, hold_n;
  logic timeout, timeout_n, found;
  assign eligible = bus.breq & ~lockout;
  rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req(eligible),
    .last(last),
    .winner(winner),
    .found(found)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      bgrant <= '0;
      ack <= '0;
      owner <= '0;
      last <= IDX_W'(NUM_MASTERS - 1);
      hold_cnt <= '0;
      lockout <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      bgrant <= bgrant_n;
      ack <= ack_n;
      owner <= owner_n;
      last <= last_n;
      hold_cnt <= hold_n;
      lockout <= lockout_n;
      timeout <= timeout_n;
    end
  end
  always_comb begin
    state_n = state;
    bgrant_n = bgrant;
    ack_n = '0;
    owner_n = owner;
    last_n = last;
    hold_n = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
    timeout_n = 1'b0;
    lockout_n = lockout & bus.breq;
    if (state == IDLE) begin
      bgrant_n = '0;
      if (found) begin
        state_n = GRANT;
        bgrant_n = NUM_MASTERS'(onehot(int'(winner)));
        ack_n = NUM_MASTERS'(onehot(int'(winner)));
        owner_n = winner;
        hold_n = '0;
      end
    end else if (!bus.breq[owner]) begin
      state_n = IDLE;
      bgrant_n = '0;
      last_n = owner;
    end else if (MAX_HOLD != 0 && hold_cnt == HC_W'(MAX_HOLD - 1)) begin
      state_n = IDLE;
      bgrant_n = '0;
      last_n = owner;
      lockout_n[owner] = 1'b1;
      timeout_n = 1'b1;
    end
  end
  assign bus.bgrant = bgrant;
  assign bus.ack = ack;
  assign bus.owner = owner;
  assign bus.busy = |bgrant;
  assign bus.timeout = timeout;
  assign bus.lockout = lockout;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed checks of rotation, release, watchdog and reset
module tb_bus_arbiter_rr;
  logic clk = 1'b0;
  logic rstn;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  bus_arbiter_rr_if #(.NUM_MASTERS(2)) i2();
  bus_arbiter_rr_if #(.NUM_MASTERS(3)) i3();
  bus_arbiter_rr_if #(.NUM_MASTERS(4)) i4();
  bus_arbiter_rr #(.NUM_MASTERS(2), .MAX_HOLD(8)) u2(.clk(clk), .rstn(rstn), .bus(i2));
  bus_arbiter_rr #(.NUM_MASTERS(3), .MAX_HOLD(256)) u3(.clk(clk), .rstn(rstn), .bus(i3));
  bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(256)) u4(.clk(clk), .rstn(rstn), .bus(i4));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rstn = 1'b0;
    i2.breq = '0;
    i3.breq = '0;
    i4.breq = '0;
    tick();
    tick();
    check("rst_bgrant", i2.bgrant, 0);
    check("rst_ack", i2.ack, 0);
    check("rst_busy", i2.busy, 0);
    check("rst_owner", i2.owner, 0);
    check("rst_timeout", i2.timeout, 0);
    check("rst_lockout", i2.lockout, 0);
    check("rst_bgrant4", i4.bgrant, 0);
    rstn = 1'b1;
    i2.breq = 2'b01;
    tick();
    check("m0_grant", i2.bgrant, 2'b01);
    check("m0_ack", i2.ack, 2'b01);
    check("m0_busy", i2.busy, 1);
    check("m0_owner", i2.owner, 0);
    tick();
    check("m0_ack_drop", i2.ack, 0);
    check("m0_hold", i2.bgrant, 2'b01);
    tick();
    tick();
    tick();
    i2.breq = 2'b00;
    tick();
    check("m0_release", i2.bgrant, 0);
    check("m0_rel_busy", i2.busy, 0);
    check("m0_rel_owner", i2.owner, 0);
    check("m0_rel_timeout", i2.timeout, 0);
    i2.breq = 2'b11;
    tick();
    check("wd_m1_grant", i2.bgrant, 2'b10);
    check("wd_m1_ack", i2.ack, 2'b10);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("wd_m1_hold%0d", i), i2.bgrant, 2'b10);
      check($sformatf("wd_to_low%0d", i), i2.timeout, 0);
    end
    tick();
    check("wd_revoke", i2.bgrant, 0);
    check("wd_timeout", i2.timeout, 1);
    check("wd_lockout", i2.lockout, 2'b10);
    tick();
    check("wd_m0_grant", i2.bgrant, 2'b01);
    check("wd_timeout_pulse", i2.timeout, 0);
    i2.breq = 2'b10;
    tick();
    check("wd_m0_release", i2.bgrant, 0);
    check("wd_lock_held", i2.lockout, 2'b10);
    tick();
    check("wd_no_regrant", i2.bgrant, 0);
    check("wd_no_busy", i2.busy, 0);
    i2.breq = 2'b00;
    tick();
    check("wd_lock_clear", i2.lockout, 0);
    i2.breq = 2'b10;
    tick();
    check("wd_m1_regrant", i2.bgrant, 2'b10);
    i2.breq = 2'b00;
    tick();
    check("wd_m1_release", i2.bgrant, 0);
    i2.breq = 2'b01;
    tick();
    check("lim_m0_grant", i2.bgrant, 2'b01);
    for (int i = 1; i < 8; i++) tick();
    check("lim_m0_hold8", i2.bgrant, 2'b01);
    i2.breq = 2'b00;
    tick();
    check("lim_release", i2.bgrant, 0);
    check("lim_no_timeout", i2.timeout, 0);
    check("lim_no_lockout", i2.lockout, 0);
    i4.breq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr4_grant%0d", k), i4.bgrant, 32'd1 << (k % 4));
      check($sformatf("rr4_ack%0d", k), i4.ack, 32'd1 << (k % 4));
      check($sformatf("rr4_owner%0d", k), i4.owner, k % 4);
      tick();
      check($sformatf("rr4_hold_a%0d", k), i4.bgrant, 32'd1 << (k % 4));
      check($sformatf("rr4_ack_drop%0d", k), i4.ack, 0);
      tick();
      check($sformatf("rr4_hold_b%0d", k), i4.bgrant, 32'd1 << (k % 4));
      i4.breq[k % 4] = 1'b0;
      tick();
      check($sformatf("rr4_idle%0d", k), i4.busy, 0);
      i4.breq[k % 4] = 1'b1;
    end
    i4.breq = '0;
    i3.breq = 3'b010;
    tick();
    check("rr3_m1_grant", i3.bgrant, 3'b010);
    i3.breq = 3'b000;
    tick();
    check("rr3_m1_release", i3.bgrant, 0);
    i3.breq = 3'b101;
    tick();
    check("rr3_m2_first", i3.bgrant, 3'b100);
    check("rr3_m2_owner", i3.owner, 2);
    i3.breq = 3'b001;
    tick();
    check("rr3_m2_release", i3.bgrant, 0);
    tick();
    check("rr3_m0_next", i3.bgrant, 3'b001);
    check("rr3_m0_owner", i3.owner, 0);
    i3.breq = 3'b100;
    tick();
    check("rr3_m0_release", i3.bgrant, 0);
    tick();
    check("rst_mid_m2", i3.bgrant, 3'b100);
    rstn = 1'b0;
    tick();
    check("rst_mid_bgrant", i3.bgrant, 0);
    check("rst_mid_busy", i3.busy, 0);
    check("rst_mid_timeout", i3.timeout, 0);
    rstn = 1'b1;
    i3.breq = 3'b101;
    tick();
    check("rst_mid_m0_first", i3.bgrant, 3'b001);
    check("rst_mid_owner", i3.owner, 0);
    i3.breq = '0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
